// File: rtl/meikyuu_move_ctrl.sv
// Per-frame player movement and room-transition controller; moves resolve one cycle after frame_tick,
// room changes TILE_LAT+3 cycles after it; frame_tick while busy is dropped, never queued.
module meikyuu_move_ctrl #(
  parameter int STEP     = 2,
  parameter int MAP_W    = 3,
  parameter int MAP_H    = 3,
  parameter int START_RX = 0,
  parameter int START_RY = 0,
  parameter int TILE_LAT = 1
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [3:0] tile_type,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [1:0] room_x,
  output logic [1:0] room_y,
  output logic       busy,
  output logic       bump,
  output logic       room_changed
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_XFER   = 2'd2;
  localparam logic [1:0] S_VERIFY = 2'd3;

  localparam logic [9:0] PX_MAX  = 10'd624;
  localparam logic [9:0] PY_MAX  = 10'd464;
  localparam logic [9:0] STEP_V  = 10'(STEP);
  localparam logic [1:0] RX_LAST = 2'(MAP_W - 1);
  localparam logic [1:0] RY_LAST = 2'(MAP_H - 1);
  localparam logic [3:0] LAT_V   = 4'(TILE_LAT);

  logic [1:0] state;
  logic [9:0] px, py;
  logic [3:0] cnt;

  // candidate computed combinationally in IDLE, held in k_* until CHECK resolves it
  logic [9:0] c_px, c_py;
  logic [1:0] c_rx, c_ry;
  logic       c_exit, c_ok, c_any;
  logic [9:0] k_px, k_py;
  logic [1:0] k_rx, k_ry;
  logic       k_exit, k_ok;

  logic [9:0] s_px, s_py;
  logic [1:0] s_rx, s_ry;

  function automatic logic collides(input logic [3:0] t, input logic [9:0] x, input logic [9:0] y);
    logic l, r, tp, b;
    l  = (x <= 10'd98);
    r  = (x >= 10'd525);
    tp = (y <= 10'd98);
    b  = (y >= 10'd365);
    case (t)
      4'd0:    collides = l | r;
      4'd1:    collides = tp | b;
      4'd2:    collides = (l & tp) | b | r;
      4'd3:    collides = (r & tp) | b | l;
      4'd4:    collides = (r & b) | tp | l;
      4'd5:    collides = (l & b) | tp | r;
      4'd6:    collides = (l | r) & (tp | b);
      default: collides = 1'b1;
    endcase
  endfunction

  always_comb begin
    c_px   = px;
    c_py   = py;
    c_rx   = room_x;
    c_ry   = room_y;
    c_exit = 1'b0;
    c_ok   = 1'b1;
    c_any  = 1'b1;
    if (btn_up) begin
      if (py == 10'd0) begin
        c_exit = 1'b1;
        c_ok   = (room_y != 2'd0);
        c_ry   = room_y - 2'd1;
        c_py   = PY_MAX;
      end else begin
        c_py = (py < STEP_V) ? 10'd0 : py - STEP_V;
      end
    end else if (btn_down) begin
      if (py == PY_MAX) begin
        c_exit = 1'b1;
        c_ok   = (room_y < RY_LAST);
        c_ry   = room_y + 2'd1;
        c_py   = 10'd0;
      end else begin
        c_py = (py > PY_MAX - STEP_V) ? PY_MAX : py + STEP_V;
      end
    end else if (btn_left) begin
      if (px == 10'd0) begin
        c_exit = 1'b1;
        c_ok   = (room_x != 2'd0);
        c_rx   = room_x - 2'd1;
        c_px   = PX_MAX;
      end else begin
        c_px = (px < STEP_V) ? 10'd0 : px - STEP_V;
      end
    end else if (btn_right) begin
      if (px == PX_MAX) begin
        c_exit = 1'b1;
        c_ok   = (room_x < RX_LAST);
        c_rx   = room_x + 2'd1;
        c_px   = 10'd0;
      end else begin
        c_px = (px > PX_MAX - STEP_V) ? PX_MAX : px + STEP_V;
      end
    end else begin
      c_any = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      px           <= 10'd312;
      py           <= 10'd232;
      room_x       <= 2'(START_RX);
      room_y       <= 2'(START_RY);
      cnt          <= 4'd0;
      k_px         <= 10'd0;
      k_py         <= 10'd0;
      k_rx         <= 2'd0;
      k_ry         <= 2'd0;
      k_exit       <= 1'b0;
      k_ok         <= 1'b0;
      s_px         <= 10'd0;
      s_py         <= 10'd0;
      s_rx         <= 2'd0;
      s_ry         <= 2'd0;
      busy         <= 1'b0;
      bump         <= 1'b0;
      room_changed <= 1'b0;
    end else begin
      bump         <= 1'b0;
      room_changed <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_tick && c_any) begin
            k_px   <= c_px;
            k_py   <= c_py;
            k_rx   <= c_rx;
            k_ry   <= c_ry;
            k_exit <= c_exit;
            k_ok   <= c_ok;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!k_exit) begin
            if (collides(tile_type, k_px, k_py)) begin
              bump <= 1'b1;
            end else begin
              px <= k_px;
              py <= k_py;
            end
            state <= S_IDLE;
          end else if (!k_ok) begin
            bump  <= 1'b1;
            state <= S_IDLE;
          end else begin
            // walls of the new room are only known once tile_type catches up
            s_px   <= px;
            s_py   <= py;
            s_rx   <= room_x;
            s_ry   <= room_y;
            px     <= k_px;
            py     <= k_py;
            room_x <= k_rx;
            room_y <= k_ry;
            cnt    <= 4'd0;
            busy   <= 1'b1;
            state  <= S_XFER;
          end
        end
        S_XFER: begin
          if (cnt == LAT_V) state <= S_VERIFY;
          else              cnt   <= cnt + 4'd1;
        end
        S_VERIFY: begin
          if (collides(tile_type, px, py)) begin
            px     <= s_px;
            py     <= s_py;
            room_x <= s_rx;
            room_y <= s_ry;
            bump   <= 1'b1;
          end else begin
            room_changed <= 1'b1;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign x_pos = px + 10'd96;
  assign y_pos = py + 10'd2;

endmodule

// File: tb/tb_meikyuu_move_ctrl.sv
// Directed bench for meikyuu_move_ctrl: two instances with different start rooms share the stimulus.
module tb_meikyuu_move_ctrl;

  logic       CLOCK_25 = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] tile_type = 4'd6;

  logic [9:0] x0, y0, x1, y1;
  logic [1:0] rx0, ry0, rx1, ry1;
  logic       busy0, bump0, rc0, busy1, bump1, rc1;

  int n_checks = 0;
  int n_fail   = 0;
  int bump_c0, rc_c0, busy_c0, bump_c1, rc_c1, busy_c1;

  always #20 CLOCK_25 = ~CLOCK_25;

  meikyuu_move_ctrl #(.START_RX(0), .START_RY(0)) u_dut0 (
    .CLOCK_25(CLOCK_25), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .tile_type(tile_type), .x_pos(x0), .y_pos(y0), .room_x(rx0), .room_y(ry0),
    .busy(busy0), .bump(bump0), .room_changed(rc0)
  );

  meikyuu_move_ctrl #(.START_RX(1), .START_RY(1)) u_dut1 (
    .CLOCK_25(CLOCK_25), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .tile_type(tile_type), .x_pos(x1), .y_pos(y1), .room_x(rx1), .room_y(ry1),
    .busy(busy1), .bump(bump1), .room_changed(rc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    bump_c0 = 0; rc_c0 = 0; busy_c0 = 0;
    bump_c1 = 0; rc_c1 = 0; busy_c1 = 0;
  endtask

  // step n cycles, sampling on the falling edge; optionally fire a tick while busy or swap the tile
  task automatic run(input int n, input bit inj_tick, input bit swap_tile);
    bit sent;
    sent = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_25);
      frame_tick = 1'b0;
      if (bump0) bump_c0++;
      if (rc0)   rc_c0++;
      if (busy0) busy_c0++;
      if (bump1) bump_c1++;
      if (rc1)   rc_c1++;
      if (busy1) busy_c1++;
      if (inj_tick && busy1 && !sent) begin
        frame_tick = 1'b1;
        sent = 1'b1;
      end
      if (swap_tile && ry1 == 2'd2) tile_type = 4'd1;
    end
  endtask

  task automatic tick(input int n);
    @(negedge CLOCK_25);
    frame_tick = 1'b1;
    run(n, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_25);
    reset = 1'b0;
    frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (2) @(negedge CLOCK_25);
    reset = 1'b1;
    clear_counts();
  endtask

  initial begin
    // reset release, idle ticks
    do_reset();
    check("rst_busy", busy0, 0);
    for (int i = 0; i < 3; i++) tick(4);
    check("idle_x0", x0, 408);
    check("idle_y0", y0, 234);
    check("idle_rx0", rx0, 0);
    check("idle_ry0", ry0, 0);
    check("idle_rx1", rx1, 1);
    check("idle_ry1", ry1, 1);
    check("idle_busy", busy_c0 + busy_c1, 0);
    check("idle_bump", bump_c0 + bump_c1, 0);
    check("idle_rc", rc_c0 + rc_c1, 0);

    // single step right, then up+right moves only vertically
    do_reset();
    tile_type = 4'd6;
    btn_right = 1'b1;
    @(negedge CLOCK_25);
    frame_tick = 1'b1;
    run(1, 1'b0, 1'b0);
    check("right_t0_x", x0, 408);
    run(1, 1'b0, 1'b0);
    check("right_t1_x", x0, 410);
    run(2, 1'b0, 1'b0);
    btn_up = 1'b1;
    tick(4);
    check("upright_y", y0, 232);
    check("upright_x", x0, 410);
    check("upright_bump", bump_c0, 0);

    // undefined tile code always collides
    do_reset();
    tile_type = 4'd7;
    btn_right = 1'b1;
    tick(4);
    check("t7_x", x0, 408);
    check("t7_bump", bump_c0, 1);

    // vertical corridor: climb to the top edge, then exit is out of grid
    do_reset();
    tile_type = 4'd0;
    btn_up = 1'b1;
    for (int i = 0; i < 116; i++) tick(3);
    check("top_y", y0, 2);
    check("top_bump_none", bump_c0, 0);
    clear_counts();
    tick(4);
    check("top_exit_y", y0, 2);
    check("top_exit_ry", ry0, 0);
    check("top_exit_bump", bump_c0, 1);
    check("top_exit_rc", rc_c0, 0);

    // L1 tile: walk right into the R band
    do_reset();
    tile_type = 4'd2;
    btn_right = 1'b1;
    for (int i = 0; i < 106; i++) tick(3);
    check("rwall_x", x0, 620);
    check("rwall_bump_none", bump_c0, 0);
    clear_counts();
    tick(4);
    check("rwall_blk_x", x0, 620);
    check("rwall_blk_bump", bump_c0, 1);

    // room change downward from (1,1), with a tick issued while busy
    do_reset();
    tile_type = 4'd6;
    btn_down = 1'b1;
    for (int i = 0; i < 116; i++) tick(3);
    check("down_edge_y", y1, 466);
    clear_counts();
    @(negedge CLOCK_25);
    frame_tick = 1'b1;
    run(14, 1'b1, 1'b0);
    check("xfer_ry", ry1, 2);
    check("xfer_rx", rx1, 1);
    check("xfer_y", y1, 2);
    check("xfer_busy_cycles", busy_c1, 3);
    check("xfer_rc", rc_c1, 1);
    check("xfer_bump", bump_c1, 0);
    check("xfer_busy_end", busy1, 0);

    // same transition, but the new room's tile rejects it
    do_reset();
    tile_type = 4'd6;
    btn_down = 1'b1;
    for (int i = 0; i < 116; i++) tick(3);
    clear_counts();
    @(negedge CLOCK_25);
    frame_tick = 1'b1;
    run(10, 1'b0, 1'b1);
    check("revert_ry", ry1, 1);
    check("revert_rx", rx1, 1);
    check("revert_y", y1, 466);
    check("revert_bump", bump_c1, 1);
    check("revert_rc", rc_c1, 0);

    // reset in the middle of a transition
    tile_type = 4'd6;
    for (int i = 0; i < 1; i++) tick(2);
    clear_counts();
    reset = 1'b0;
    run(3, 1'b0, 1'b0);
    check("midrst_y", y1, 234);
    check("midrst_ry", ry1, 1);
    check("midrst_busy", busy1, 0);
    check("midrst_pulses", bump_c1 + rc_c1, 0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
